// File: rtl/cordic_channel_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// cordic_channel_scheduler_pkg
// Shared settings for the CORDIC channel scheduler: data width, channel
// count, core latency, the tag that travels beside each sample through the
// core, and a small modulo-NUM_CH helper used by the round-robin arbiter.
// ---------------------------------------------------------------------------
package cordic_channel_scheduler_pkg;

  localparam int SIZE_DATA      = 16;
  localparam int NUM_CH         = 4;
  localparam int CORDIC_LATENCY = 18;
  localparam int CH_W           = $clog2(NUM_CH);

  // Tag carried alongside a sample while it is inside the core
  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
  } sched_tag_t;

  // Fold a value in [0, 2*NUM_CH) back into [0, NUM_CH)
  function automatic logic [CH_W-1:0] ch_wrap(input logic [CH_W:0] val);
    logic [CH_W:0] res;
    res = (val >= (CH_W+1)'(NUM_CH)) ? (val - (CH_W+1)'(NUM_CH)) : val;
    return res[CH_W-1:0];
  endfunction

endpackage

// File: rtl/cordic_channel_scheduler_if.sv
// ---------------------------------------------------------------------------
// cordic_channel_scheduler_if
// Bundles the requester handshake, the core issue/return path and the
// result stream of the scheduler.
//   slave  : view of the scheduler itself
//   master : view of the surroundings (requesters, core, result consumer)
// Signals:
//   ch_enable / req_valid / req_i / req_q  requester side, packed per channel
//   req_ready                              one-hot (or zero) grant
//   core_vld / core_i / core_q             registered sample towards the core
//   core_amp / core_ph                     core outputs, fixed latency later
//   res_valid / res_ch / res_amp / res_ph  tagged result stream
//   busy                                   something still in flight
// ---------------------------------------------------------------------------
interface cordic_channel_scheduler_if;
  import cordic_channel_scheduler_pkg::*;

  logic [NUM_CH-1:0]           ch_enable;
  logic [NUM_CH-1:0]           req_valid;
  logic [NUM_CH-1:0]           req_ready;
  logic [NUM_CH*SIZE_DATA-1:0] req_i;
  logic [NUM_CH*SIZE_DATA-1:0] req_q;
  logic                        core_vld;
  logic [SIZE_DATA-1:0]        core_i;
  logic [SIZE_DATA-1:0]        core_q;
  logic [SIZE_DATA-1:0]        core_amp;
  logic [SIZE_DATA-1:0]        core_ph;
  logic                        res_valid;
  logic [CH_W-1:0]             res_ch;
  logic [SIZE_DATA-1:0]        res_amp;
  logic [SIZE_DATA-1:0]        res_ph;
  logic                        busy;

  modport slave (
    input  ch_enable, req_valid, req_i, req_q, core_amp, core_ph,
    output req_ready, core_vld, core_i, core_q,
           res_valid, res_ch, res_amp, res_ph, busy
  );

  modport master (
    output ch_enable, req_valid, req_i, req_q, core_amp, core_ph,
    input  req_ready, core_vld, core_i, core_q,
           res_valid, res_ch, res_amp, res_ph, busy
  );

endinterface

// File: rtl/cordic_channel_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter with a registered start pointer.
// Ports:
//   clk, reset    clock, asynchronous active-low reset
//   req_i         per-channel request
//   enable_i      per-channel enable; a disabled channel is never granted
//   grant_o       one-hot grant, zero when nothing is eligible
//   grant_idx_o   index of the granted channel (valid with grant_vld_o)
//   grant_vld_o   a grant is being issued this cycle
// Every grant is a transfer (a grant implies a request), so the pointer
// advances to the channel after the winner whenever grant_vld_o is high.
// ---------------------------------------------------------------------------
module rr_arbiter
  import cordic_channel_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] enable_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [CH_W-1:0]   grant_idx_o,
  output logic              grant_vld_o
);

  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   ptr_d;
  logic [NUM_CH-1:0] eligible_s;
  logic [CH_W-1:0]   cand_s;
  logic [CH_W-1:0]   idx_s;
  logic              found_s;

  assign eligible_s = req_i & enable_i;

  // Search from the pointer, wrapping, and pick the first eligible channel
  always_comb begin
    found_s = 1'b0;
    idx_s   = '0;
    cand_s  = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      cand_s = ch_wrap({1'b0, ptr_q} + (CH_W+1)'(off));
      if (!found_s && eligible_s[cand_s]) begin
        found_s = 1'b1;
        idx_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Decode the winner into a one-hot grant and the next pointer value
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    if (found_s) begin
      grant_o[idx_s] = 1'b1;
      ptr_d          = ch_wrap({1'b0, idx_s} + (CH_W+1)'(1));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin start pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign grant_idx_o = idx_s;
  assign grant_vld_o = found_s;

endmodule

// File: rtl/cordic_channel_scheduler.sv
// ---------------------------------------------------------------------------
// cordic_channel_scheduler
// Shares one fixed-latency, fully pipelined CORDIC vectoring core among
// NUM_CH I/Q requesters. At most one sample per cycle is granted by a
// round-robin arbiter and registered into the core; a {vld, ch} tag pipe
// runs beside the core so each result leaves labelled with its source.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    scheduler view (slave) of cordic_channel_scheduler_if
// Timing: a handshake at edge k registers core_i/core_q at edge k, the tag
// enters the pipe at edge k+1 and the result register loads at edge
// k+CORDIC_LATENCY+1, the same edge at which the core output is sampled.
// ---------------------------------------------------------------------------
module cordic_channel_scheduler
  import cordic_channel_scheduler_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  cordic_channel_scheduler_if.slave   bus
);

  logic [NUM_CH-1:0]    grant_s;
  logic [CH_W-1:0]      grant_idx_s;
  logic                 grant_vld_s;
  logic [SIZE_DATA-1:0] sel_i_s;
  logic [SIZE_DATA-1:0] sel_q_s;

  logic                 core_vld_q;
  logic [CH_W-1:0]      core_ch_q;
  logic [SIZE_DATA-1:0] core_i_q;
  logic [SIZE_DATA-1:0] core_q_q;
  logic [SIZE_DATA-1:0] core_i_d;
  logic [SIZE_DATA-1:0] core_q_d;

  sched_tag_t           tag_q [CORDIC_LATENCY];
  sched_tag_t           tail_s;
  logic                 any_tag_s;

  logic                 res_valid_q;
  logic [CH_W-1:0]      res_ch_q;
  logic [SIZE_DATA-1:0] res_amp_q;
  logic [SIZE_DATA-1:0] res_ph_q;
  logic                 busy_q;
  logic                 busy_d;

  rr_arbiter u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_i       (bus.req_valid),
    .enable_i    (bus.ch_enable),
    .grant_o     (grant_s),
    .grant_idx_o (grant_idx_s),
    .grant_vld_o (grant_vld_s)
  );

  // Grants are suppressed while reset is asserted so ready reads 0 then
  assign bus.req_ready = grant_s & {NUM_CH{reset}};

  // One-hot AND-OR mux of the granted channel's sample
  always_comb begin
    sel_i_s = '0;
    sel_q_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_i_s = sel_i_s | (bus.req_i[c*SIZE_DATA +: SIZE_DATA] & {SIZE_DATA{grant_s[c]}});
      sel_q_s = sel_q_s | (bus.req_q[c*SIZE_DATA +: SIZE_DATA] & {SIZE_DATA{grant_s[c]}});
    end
  end

  // Issue data holds its last value when nothing is granted
  always_comb begin
    core_i_d = core_i_q;
    core_q_d = core_q_q;
    if (grant_vld_s) begin
      core_i_d = sel_i_s;
      core_q_d = sel_q_s;
    end else begin
      core_i_d = core_i_q;
      core_q_d = core_q_q;
    end
  end

  // Issue registers towards the core
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_vld_q <= 1'b0;
      core_ch_q  <= '0;
      core_i_q   <= '0;
      core_q_q   <= '0;
    end else begin
      core_vld_q <= grant_vld_s;
      core_ch_q  <= grant_vld_s ? grant_idx_s : core_ch_q;
      core_i_q   <= core_i_d;
      core_q_q   <= core_q_d;
    end
  end

  // Tag pipe: never stalls, cleared by reset so in-flight samples vanish
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < CORDIC_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= {core_vld_q, core_ch_q};
      for (int s = 1; s < CORDIC_LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign tail_s = tag_q[CORDIC_LATENCY-1];

  // Any valid tag still travelling through the core
  always_comb begin
    any_tag_s = 1'b0;
    for (int s = 0; s < CORDIC_LATENCY; s++) begin
      any_tag_s = any_tag_s | tag_q[s].vld;
    end
  end

  // Registered busy: OR of the next-cycle valid bits of every holding stage
  // (issue register, tag pipe, result register), so it drops the cycle
  // after the last result strobe.
  assign busy_d = grant_vld_s | core_vld_q | any_tag_s;

  // Result registers: capture the core output when the tag tail is valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_amp_q   <= '0;
      res_ph_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      res_valid_q <= tail_s.vld;
      res_ch_q    <= tail_s.vld ? tail_s.ch    : res_ch_q;
      res_amp_q   <= tail_s.vld ? bus.core_amp : res_amp_q;
      res_ph_q    <= tail_s.vld ? bus.core_ph  : res_ph_q;
      busy_q      <= busy_d;
    end
  end

  assign bus.core_vld  = core_vld_q;
  assign bus.core_i    = core_i_q;
  assign bus.core_q    = core_q_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_ch    = res_ch_q;
  assign bus.res_amp   = res_amp_q;
  assign bus.res_ph    = res_ph_q;
  assign bus.busy      = busy_q;

endmodule
